// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and constants for the tail-light scheduler.
//   mode_t         : active mode encoding (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3)
//   NUM_PHASES     : phases per sweep
//   PHASE_W        : phase counter width
//   COMFORT_SWEEPS : sweeps granted by a turn tap when TLC_COMFORT_BLINK_EN is defined
//   decode_request : driver request priority decode
package tlc_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  localparam int NUM_PHASES     = 4;
  localparam int PHASE_W        = 2;
  localparam int COMFORT_SWEEPS = 3;

  // Hazard wins; a single turn selects its side; both turns is ambiguous -> IDLE.
  function automatic mode_t decode_request(input logic hazard, input logic left,
                                           input logic right);
    mode_t m;
    if (hazard)              m = MODE_HAZARD;
    else if (left && !right) m = MODE_LEFT;
    else if (right && !left) m = MODE_RIGHT;
    else                     m = MODE_IDLE;
    return m;
  endfunction

endpackage

// File: rtl/tlc_step_prescaler.sv
// tlc_step_prescaler: divides clk into one tick every STEP_DIV cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count while high; counter held at 0 while low
//   clear      : synchronous restart of the count at 0
//   tick       : high during the cycle the count sits at STEP_DIV-1
module tlc_step_prescaler #(
  parameter int STEP_DIV = 4,
  parameter int DIV_W    = $clog2(STEP_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || !enable) cnt <= '0;
    else if (cnt == LAST)      cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/tail_light_scheduler.sv
// tail_light_scheduler: arbitrates brake/turn/hazard requests into one active
// mode and produces the step tick and 4-phase sweep for the light pattern unit.
// Optional build macro: TLC_COMFORT_BLINK_EN (a turn tap yields 3 full sweeps).
//   clk, rst_n    : clock, asynchronous active-low reset
//   brake_i       : brake request (level)
//   turn_left_i   : left turn request (level)
//   turn_right_i  : right turn request (level)
//   hazard_i      : hazard switch (level)
//   mode_o        : active mode (IDLE/LEFT/RIGHT/HAZARD)
//   phase_o       : sweep phase 0..3
//   step_o        : one-clk pulse per phase advance
//   frame_end_o   : one-clk pulse when phase wraps 3->0
//   brake_o       : brake_i delayed one clk
//   busy_o        : mode_o != IDLE
// Mode changes happen only at a sweep wrap, except entry from IDLE and
// hazard pre-emption, which restart the sweep at phase 0 immediately.
module tail_light_scheduler
  import tlc_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int DIV_W    = $clog2(STEP_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brake_i,
  input  logic       turn_left_i,
  input  logic       turn_right_i,
  input  logic       hazard_i,
  output logic [1:0] mode_o,
  output logic [1:0] phase_o,
  output logic       step_o,
  output logic       frame_end_o,
  output logic       brake_o,
  output logic       busy_o
);

  mode_t              mode_q, mode_d, req;
  logic [PHASE_W-1:0] phase_q;
  logic               tick, wrap, preempt, restart, hold;

  assign req     = decode_request(hazard_i, turn_left_i, turn_right_i);
  assign wrap    = tick && (phase_q == PHASE_W'(NUM_PHASES - 1));
  assign preempt = (req == MODE_HAZARD) && (mode_q != MODE_HAZARD);

  tlc_step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (mode_q != MODE_IDLE),
    .clear  (restart),
    .tick   (tick)
  );

`ifdef TLC_COMFORT_BLINK_EN
  logic [1:0] credit_q;
  logic       opposite;

  assign opposite = ((mode_q == MODE_LEFT)  && (req == MODE_RIGHT)) ||
                    ((mode_q == MODE_RIGHT) && (req == MODE_LEFT));
  // Credit is decremented at this wrap; hold only if some remains afterwards.
  assign hold = (credit_q > 2'd1) && !opposite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       credit_q <= 2'd0;
    else if (preempt)                                 credit_q <= 2'd0;
    else if (restart && (mode_q == MODE_IDLE) &&
             ((req == MODE_LEFT) || (req == MODE_RIGHT))) credit_q <= 2'(COMFORT_SWEEPS);
    else if (restart)                                 credit_q <= 2'd0;
    else if (wrap && (credit_q != 2'd0))              credit_q <= credit_q - 2'd1;
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    mode_d  = mode_q;
    restart = 1'b0;
    if (preempt) begin
      mode_d  = MODE_HAZARD;
      restart = 1'b1;
    end else if (mode_q == MODE_IDLE) begin
      if (req != MODE_IDLE) begin
        mode_d  = req;
        restart = 1'b1;
      end
    end else if (wrap && (req != mode_q) && !hold) begin
      mode_d  = req;
      restart = 1'b1;
    end
  end

  // FSM state, sweep phase and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_IDLE;
      phase_q     <= '0;
      step_o      <= 1'b0;
      frame_end_o <= 1'b0;
      brake_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      if (restart)   phase_q <= '0;
      else if (tick) phase_q <= phase_q + 1'b1;
      // A hazard restart replaces any coincident step/wrap.
      step_o      <= tick && !preempt;
      frame_end_o <= wrap && !preempt;
      brake_o     <= brake_i;
      busy_o      <= (mode_d != MODE_IDLE);
    end
  end

  assign mode_o  = mode_q;
  assign phase_o = phase_q;

endmodule

// File: tb/tb_tail_light_scheduler.sv
// tb_tail_light_scheduler: directed bench for tail_light_scheduler (STEP_DIV=4).
module tb_tail_light_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brake_i = 1'b0, turn_left_i = 1'b0, turn_right_i = 1'b0, hazard_i = 1'b0;
  logic [1:0] mode_o, phase_o;
  logic       step_o, frame_end_o, brake_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tail_light_scheduler #(.STEP_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .brake_i      (brake_i),
    .turn_left_i  (turn_left_i),
    .turn_right_i (turn_right_i),
    .hazard_i     (hazard_i),
    .mode_o       (mode_o),
    .phase_o      (phase_o),
    .step_o       (step_o),
    .frame_end_o  (frame_end_o),
    .brake_o      (brake_o),
    .busy_o       (busy_o)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_mode"},  {6'd0, mode_o},  8'd0);
    check_eq({tag, "_phase"}, {6'd0, phase_o}, 8'd0);
    check_eq({tag, "_busy"},  {7'd0, busy_o},  8'd0);
  endtask

  initial begin : main
    int steps;
    logic bexp;

    // Reset values (asynchronous, before any clock edge)
    #2;
    check_idle("rst");
    check_eq("rst_step", {7'd0, step_o}, 8'd0);
    check_eq("rst_fe",   {7'd0, frame_end_o}, 8'd0);
    check_eq("rst_brake", {7'd0, brake_o}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 20 clocks: no steps
    steps = 0;
    for (int k = 0; k < 20; k++) begin
      step_clk();
      steps += int'(step_o);
    end
    check_eq("idle20_steps", 8'(steps), 8'd0);
    check_idle("idle20");

    // RIGHT held: full sweep model with brake toggles overlaid
    turn_right_i = 1'b1;
    step_clk();
    check_eq("right_entry_mode", {6'd0, mode_o}, 8'd2);
    check_eq("right_entry_busy", {7'd0, busy_o}, 8'd1);
    check_eq("right_entry_phase", {6'd0, phase_o}, 8'd0);
    bexp = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step_clk();
      check_eq("sweep_step",  {7'd0, step_o},      8'((k % 4) == 0));
      check_eq("sweep_phase", {6'd0, phase_o},     8'((k / 4) % 4));
      check_eq("sweep_fe",    {7'd0, frame_end_o}, 8'(k == 16));
      check_eq("sweep_mode",  {6'd0, mode_o},      8'd2);
      check_eq("brake_follow", {7'd0, brake_o},    {7'd0, bexp});
      brake_i = (k >= 5) && (k < 9);
      bexp    = brake_i;
    end
    // Drop request; mode persists until the next wrap (16 clks later)
    turn_right_i = 1'b0;
    brake_i = 1'b0;
    run(15);
    check_eq("right_hold_mode", {6'd0, mode_o}, 8'd2);
    check_eq("right_hold_phase", {6'd0, phase_o}, 8'd3);
    step_clk();
    check_idle("right_exit");
    check_eq("right_exit_fe", {7'd0, frame_end_o}, 8'd1);
    step_clk();
    check_eq("right_exit_nostep", {7'd0, step_o}, 8'd0);

    // LEFT tap dropped at phase 1: IDLE 16 clks after entry
    turn_left_i = 1'b1;
    step_clk();
    check_eq("left_entry_mode", {6'd0, mode_o}, 8'd1);
    run(4);
    check_eq("left_phase1", {6'd0, phase_o}, 8'd1);
    turn_left_i = 1'b0;
    run(11);
    check_eq("left_tap_hold", {6'd0, mode_o}, 8'd1);
    step_clk();
`ifdef TLC_COMFORT_BLINK_EN
    check_eq("left_tap_credit", {6'd0, mode_o}, 8'd1);
    run(32);
`endif
    check_idle("left_tap_exit");

    // LEFT at phase 2, hazard rises: immediate restart
    turn_left_i = 1'b1;
    step_clk();
    run(9);
    check_eq("pre_hz_phase", {6'd0, phase_o}, 8'd2);
    hazard_i = 1'b1;
    step_clk();
    check_eq("hz_mode", {6'd0, mode_o}, 8'd3);
    check_eq("hz_phase", {6'd0, phase_o}, 8'd0);
    run(3);
    check_eq("hz_nostep", {7'd0, step_o}, 8'd0);
    step_clk();
    check_eq("hz_step", {7'd0, step_o}, 8'd1);
    check_eq("hz_step_phase", {6'd0, phase_o}, 8'd1);
    hazard_i = 1'b0;
    turn_left_i = 1'b0;
    run(11);
    check_eq("hz_hold", {6'd0, mode_o}, 8'd3);
    step_clk();
    check_idle("hz_exit");

    // Hazard coincident with a wrap tick: restart wins
    turn_right_i = 1'b1;
    step_clk();
    run(15);
    hazard_i = 1'b1;
    step_clk();
    check_eq("wrap_hz_mode", {6'd0, mode_o}, 8'd3);
    check_eq("wrap_hz_phase", {6'd0, phase_o}, 8'd0);
    run(3);
    check_eq("wrap_hz_nostep", {7'd0, step_o}, 8'd0);
    step_clk();
    check_eq("wrap_hz_step", {7'd0, step_o}, 8'd1);
    hazard_i = 1'b0;
    turn_right_i = 1'b0;
    run(12);
    check_idle("wrap_hz_exit");

    // Both turns without hazard: stays IDLE
    turn_left_i = 1'b1;
    turn_right_i = 1'b1;
    run(6);
    check_idle("both_turns");
    turn_left_i = 1'b0;
    turn_right_i = 1'b0;

    // Asynchronous reset mid-sweep
    turn_right_i = 1'b1;
    run(7);
    check_eq("pre_rst_busy", {7'd0, busy_o}, 8'd1);
    brake_i = 1'b1;
    step_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_brake", {7'd0, brake_o}, 8'd0);
    check_eq("async_rst_step", {7'd0, step_o}, 8'd0);
    turn_right_i = 1'b0;
    brake_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    check_idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
